// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract sequencer: W-bit operands pass LSB-first through one
// full-adder cell, with a carry flip-flop linking successive bits.
module serial_add_ctrl #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a_in,
    input  logic [W-1:0] b_in,
    input  logic         c_in,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum_out,
    output logic         c_out,
    output logic         ovf,
    output logic         busy
);

    localparam int unsigned CNT_W = $clog2(W + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [W-1:0]     a_sh;
    logic [W-1:0]     b_sh;
    logic [W-1:0]     s_sh;
    logic             carry;
    logic [CNT_W-1:0] cnt;

    logic             fa_s;
    logic             fa_c;
    logic [W-1:0]     s_next;

    // Single full-adder cell plus the sum shift-in (written with shifts so W=1 stays legal)
    always_comb begin
        fa_s   = a_sh[0] ^ b_sh[0] ^ carry;
        fa_c   = (a_sh[0] & b_sh[0]) | (carry & (a_sh[0] ^ b_sh[0]));
        s_next = (s_sh >> 1) | (W'(fa_s) << (W - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            sum_out   <= '0;
            c_out     <= 1'b0;
            ovf       <= 1'b0;
            a_sh      <= '0;
            b_sh      <= '0;
            s_sh      <= '0;
            carry     <= 1'b0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        // Subtraction is A + ~B + ~c_in
                        a_sh     <= a_in;
                        b_sh     <= sub ? ~b_in : b_in;
                        carry    <= c_in ^ sub;
                        cnt      <= '0;
                        state    <= RUN;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                RUN: begin
                    s_sh  <= s_next;
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    carry <= fa_c;
                    cnt   <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(W - 1)) begin
                        // carry still holds the carry into the MSB on this edge
                        state     <= DONE;
                        out_valid <= 1'b1;
                        sum_out   <= s_next;
                        c_out     <= fa_c;
                        ovf       <= fa_c ^ carry;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed-vector bench for serial_add_ctrl (W=8): table of hand-computed
// results, stall/ignore and mid-run reset sequences, and a random sweep.
module tb_serial_add_ctrl;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         c_in;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum_out;
    logic         c_out;
    logic         ovf;
    logic         busy;

    int tests = 0;
    int fails = 0;

    serial_add_ctrl #(.W(W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a_in(a_in), .b_in(b_in), .c_in(c_in), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum_out(sum_out), .c_out(c_out), .ovf(ovf), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic       sb;
        logic [7:0] sum;
        logic       co;
        logic       ov;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: whole-word arithmetic, returns {ovf, c_out, sum}
    function automatic logic [9:0] ref_op(input logic [7:0] a, input logic [7:0] b,
                                          input logic cin, input logic sb);
        logic [7:0] bb;
        logic       cc;
        logic [8:0] full;
        logic [7:0] low;
        bb   = sb ? ~b : b;
        cc   = sb ? ~cin : cin;
        full = {1'b0, a} + {1'b0, bb} + 9'(cc);
        low  = {1'b0, a[6:0]} + {1'b0, bb[6:0]} + 8'(cc);
        return {low[7] ^ full[8], full[8], full[7:0]};
    endfunction

    // Present operands at a falling edge and let the next rising edge accept them
    task automatic start_op(input logic [7:0] a, input logic [7:0] b,
                            input logic cin, input logic sb);
        @(negedge clk);
        check("in_ready_before_accept", 32'(in_ready), 32'd1);
        a_in = a; b_in = b; c_in = cin; sub = sb; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        a_in = ~a; b_in = ~b; c_in = ~cin; sub = ~sb;
        check("busy_in_run", 32'(busy), 32'd1);
    endtask

    // Counts rising edges after accept until out_valid is seen (bounded)
    task automatic wait_done(output int lat);
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic check_result(input string tag, input logic [7:0] a, input logic [7:0] b,
                                input logic cin, input logic sb,
                                input logic [7:0] es, input logic eco, input logic eov,
                                input int lat);
        check({tag, "_latency"}, 32'(lat), 32'(W));
        check({tag, "_sum"}, 32'(sum_out), 32'(es));
        check({tag, "_c_out"}, 32'(c_out), 32'(eco));
        check({tag, "_ovf"}, 32'(ovf), 32'(eov));
    endtask

    vec_t vecs[9];

    initial begin
        int         lat;
        logic [9:0] r;
        logic [7:0] ra, rb;
        logic       rc, rs;

        vecs[0] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0};
        vecs[3] = '{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0};
        vecs[4] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
        vecs[5] = '{8'h10, 8'h20, 1'b0, 1'b0, 8'h30, 1'b0, 1'b0};
        vecs[6] = '{8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[7] = '{8'h00, 8'h00, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0};
        vecs[8] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a_in = '0; b_in = '0; c_in = 1'b0; sub = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_sum", 32'(sum_out), 32'd0);
        check("reset_c_out", 32'(c_out), 32'd0);
        check("reset_ovf", 32'(ovf), 32'd0);
        rst = 1'b0;

        // Directed table
        for (int i = 0; i < 9; i++) begin
            start_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sb);
            wait_done(lat);
            check_result($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin,
                         vecs[i].sb, vecs[i].sum, vecs[i].co, vecs[i].ov, lat);
            @(posedge clk);
            @(negedge clk);
            check("done_one_cycle", 32'(out_valid), 32'd0);
            check("idle_keeps_sum", 32'(sum_out), 32'(vecs[i].sum));
        end

        // Stall in DONE, with a competing request that must be ignored
        out_ready = 1'b0;
        start_op(8'h7F, 8'h01, 1'b0, 1'b0);
        wait_done(lat);
        check_result("stall", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, lat);
        a_in = 8'h11; b_in = 8'h22; c_in = 1'b1; sub = 1'b1; in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            @(negedge clk);
            check("stall_out_valid", 32'(out_valid), 32'd1);
            check("stall_in_ready", 32'(in_ready), 32'd0);
            check("stall_sum", 32'(sum_out), 32'h80);
            check("stall_flags", 32'({c_out, ovf}), 32'b01);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("release_in_ready", 32'(in_ready), 32'd1);
        check("release_out_valid", 32'(out_valid), 32'd0);
        check("release_busy", 32'(busy), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("no_queued_accept", 32'(busy), 32'd0);

        // Reset in the 4th RUN cycle discards the operation
        start_op(8'h33, 8'h44, 1'b0, 1'b0);
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst = 1'b1;
        #1;
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_sum", 32'(sum_out), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < W + 2; k++) begin
            @(posedge clk);
            @(negedge clk);
            check("midrst_no_pulse", 32'(out_valid), 32'd0);
        end
        start_op(8'h10, 8'h20, 1'b0, 1'b0);
        wait_done(lat);
        check_result("after_rst", 8'h10, 8'h20, 1'b0, 1'b0, 8'h30, 1'b0, 1'b0, lat);
        @(posedge clk);

        // Random sweep against the word-level reference
        for (int n = 0; n < 1000; n++) begin
            ra = 8'($urandom); rb = 8'($urandom);
            rc = 1'($urandom); rs = 1'($urandom);
            r  = ref_op(ra, rb, rc, rs);
            start_op(ra, rb, rc, rs);
            wait_done(lat);
            check_result("rand", ra, rb, rc, rs, r[7:0], r[8], r[9], lat);
            @(posedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
